// File: rtl/pipe_latch_pkg.sv
// Shared types for the pipe_latch skid buffer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pipe_latch_pkg;

  // Occupancy of the two-entry latch: nothing held, main only, main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } latch_state_e;

endpackage

// File: rtl/pipe_latch_sat_counter.sv
// Saturating up-counter; sticks at all-ones until reset.
// Latency: count visible the cycle after inc_i is sampled high.
// Backpressure: none, free-running on inc_i.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset, clears the count
//   inc_i  - add one this cycle unless already saturated
//   cnt_o  - current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_latch.sv
// Two-entry skid latch between pipeline stages (main register + one overflow slot).
// Latency: one cycle from accept to out_valid when empty; strict FIFO order.
// Backpressure: in_ready drops only when both slots are held, decoded from state.
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   flush                 - drop held and incoming entries (highest priority)
//   in_valid/in_ready     - upstream handshake, in_data/in_ctrl payload
//   out_valid/out_ready   - downstream handshake, out_data/out_ctrl registered payload
//   bubble_cnt            - saturating count of cycles downstream was ready but starved
module pipe_latch
  import pipe_latch_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  latch_state_e      state_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;

  logic accept;
  logic consume;

  // Handshake flags come purely from registered state, so no input reaches
  // in_ready or out_valid combinationally.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_NOP;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_NOP;
    end else if (flush) begin
      // A consume this cycle still completes downstream; anything accepted is lost.
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_NOP;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_NOP;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (consume && accept) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
          end else if (consume) begin
            // Main is cleared so an idle latch presents a harmless NOP.
            main_data_q <= '0;
            main_ctrl_q <= CTRL_NOP;
            state_q     <= ST_EMPTY;
          end else if (accept) begin
            skid_data_q <= in_data;
            skid_ctrl_q <= in_ctrl;
            state_q     <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (consume) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
            skid_data_q <= '0;
            skid_ctrl_q <= CTRL_NOP;
            state_q     <= ST_ONE;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          main_data_q <= '0;
          main_ctrl_q <= CTRL_NOP;
          skid_data_q <= '0;
          skid_ctrl_q <= CTRL_NOP;
        end
      endcase
    end
  end

  assign out_data = main_data_q;
  assign out_ctrl = main_ctrl_q;

  // Counts starved-but-ready cycles; flush deliberately does not touch it.
  sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (~out_valid & out_ready),
    .cnt_o (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_latch.sv
module tb_pipe_latch;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int NW = 4;
  localparam logic [CW-1:0] NOP = 16'h00F0;
  localparam int BUB_MAX = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [NW-1:0] bubble_cnt;

  int total = 0;
  int bad = 0;

  // Reference model: an ordered queue of held entries (capacity 2) plus a
  // saturating starvation counter.
  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;
  ent_t mq[$];
  int   m_bub = 0;

  always #5 clk = ~clk;

  pipe_latch #(
    .DATA_W   (DW),
    .CTRL_W   (CW),
    .CTRL_NOP (NOP),
    .CNT_W    (NW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .bubble_cnt (bubble_cnt)
  );

  // Advance one clock, updating the model from the inputs presented this cycle.
  task automatic tick();
    bit   acc;
    bit   con;
    bit   bub;
    ent_t e;
    acc = in_valid && (mq.size() < 2);
    con = out_ready && (mq.size() > 0);
    bub = out_ready && (mq.size() == 0);
    e.d = in_data;
    e.c = in_ctrl;
    @(posedge clk);
    if (bub && (m_bub < BUB_MAX)) m_bub++;
    if (flush) begin
      mq.delete();
    end else begin
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    in_ctrl = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    m_bub = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    in_ctrl = '0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    total++; if (out_ctrl !== NOP) begin bad++; $display("FAIL reset_out_ctrl got=%h exp=%h", out_ctrl, NOP); end
    total++; if (bubble_cnt !== '0) begin bad++; $display("FAIL reset_bubble got=%0d exp=0", bubble_cnt); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    m_bub = 0;
  endtask

  task automatic test_single();
    in_valid = 1'b1;
    in_data = 32'h11;
    in_ctrl = 16'h0A0B;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
    total++; if (out_data !== 32'h11) begin bad++; $display("FAIL single_data got=%h exp=11", out_data); end
    total++; if (out_ctrl !== 16'h0A0B) begin bad++; $display("FAIL single_ctrl got=%h exp=0a0b", out_ctrl); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready got=%0b exp=1", in_ready); end
    total++; if (bubble_cnt !== 4'd1) begin bad++; $display("FAIL single_bubble got=%0d exp=1", bubble_cnt); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%0b exp=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL drain_data got=%h exp=0", out_data); end
    total++; if (out_ctrl !== NOP) begin bad++; $display("FAIL drain_ctrl got=%h exp=%h", out_ctrl, NOP); end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1; in_data = 32'h1; in_ctrl = 16'h0001; out_ready = 1'b1;
    tick();
    in_data = 32'h2; in_ctrl = 16'h0002; out_ready = 1'b0;
    tick();
    in_data = 32'h3; in_ctrl = 16'h0003;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
    total++; if (out_data !== 32'h1) begin bad++; $display("FAIL full_data got=%h exp=1", out_data); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%0b exp=1", out_valid); end
    tick();
    total++; if (out_data !== 32'h1) begin bad++; $display("FAIL full_hold_data got=%h exp=1", out_data); end
    out_ready = 1'b1;
    tick();
    total++; if (out_data !== 32'h2) begin bad++; $display("FAIL bp_second got=%h exp=2", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_again got=%0b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_data !== 32'h3) begin bad++; $display("FAIL bp_third got=%h exp=3", out_data); end
    total++; if (out_ctrl !== 16'h0003) begin bad++; $display("FAIL bp_third_ctrl got=%h exp=0003", out_ctrl); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_data = 32'hA; in_ctrl = 16'h1111;
    tick();
    in_data = 32'hB; in_ctrl = 16'h2222;
    tick();
    flush = 1'b1; in_data = 32'h55; in_ctrl = 16'h5555;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
    total++; if (out_ctrl !== NOP) begin bad++; $display("FAIL flush_ctrl got=%h exp=%h", out_ctrl, NOP); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL flush_data got=%h exp=0", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b0 || out_data === 32'h55) begin
        bad++; $display("FAIL flush_gone valid=%0b data=%h exp valid=0", out_valid, out_data);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1; in_data = 32'h33; in_ctrl = 16'h3333;
    tick();
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%0b exp=0", out_valid); end
    total++; if (out_ctrl !== NOP) begin bad++; $display("FAIL areset_ctrl got=%h exp=%h", out_ctrl, NOP); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL areset_data got=%h exp=0", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL areset_in_ready got=%0b exp=1", in_ready); end
    mq.delete();
    m_bub = 0;
    #2;
    reset = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 32'h77; in_ctrl = 16'h1234;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL post_reset_valid got=%0b exp=1", out_valid); end
    total++; if (out_data !== 32'h77) begin bad++; $display("FAIL post_reset_data got=%h exp=77", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_bubble_sat();
    int exp;
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      flush = (i == 8);
      tick();
      flush = 1'b0;
      exp = (i < BUB_MAX) ? i : BUB_MAX;
      total++; if (bubble_cnt !== exp[NW-1:0]) begin
        bad++; $display("FAIL bubble_step%0d got=%0d exp=%0d", i, bubble_cnt, exp);
      end
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (bubble_cnt !== 4'd15) begin bad++; $display("FAIL bubble_hold got=%0d exp=15", bubble_cnt); end
  endtask

  task automatic test_random();
    logic          ev;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    do_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      ev = (mq.size() > 0);
      ed = ev ? mq[0].d : '0;
      ec = ev ? mq[0].c : NOP;
      total++; if (out_valid !== ev) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, ev); end
      total++; if (in_ready !== (mq.size() < 2)) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, mq.size() < 2); end
      total++; if (out_data !== ed) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, out_data, ed); end
      total++; if (out_ctrl !== ec) begin bad++; $display("FAIL rnd_ctrl cyc=%0d got=%h exp=%h", cyc, out_ctrl, ec); end
      total++; if (bubble_cnt !== m_bub[NW-1:0]) begin bad++; $display("FAIL rnd_bubble cyc=%0d got=%0d exp=%0d", cyc, bubble_cnt, m_bub); end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_data   = $urandom;
      in_ctrl   = CW'($urandom);
      // Occasional starvation reset keeps the bubble counter moving.
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        tick();
      end
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_bubble_sat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_latch.md
PIPE_LATCH -- requirements
Module: pipe_latch

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the data payload field.
REQ-002 SHALL have parameter CTRL_W, default 16, width of the control-signal bundle.
REQ-003 SHALL have parameter CTRL_NOP, default all-zero (CTRL_W bits), control value meaning "no side effects" (write/mem/branch disabled).
REQ-004 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 flush  input  1  discard all held and incoming entries (misprediction).
REQ-008 in_valid  input  1  upstream offers an entry.
REQ-009 in_ready  output  1  latch can accept an entry this cycle.
REQ-010 in_data  input  DATA_W  upstream data payload.
REQ-011 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-012 out_valid  output  1  out_data/out_ctrl hold a live entry.
REQ-013 out_ready  input  1  downstream consumes the entry this cycle.
REQ-014 out_data  output  DATA_W  registered data payload.
REQ-015 out_ctrl  output  CTRL_W  registered control bundle.
REQ-016 bubble_cnt  output  CNT_W  saturating count of cycles with out_valid=0 and out_ready=1.

Function
REQ-017 SHALL implement a 2-entry skid latch: main register drives outputs; skid register holds one overflow entry.
REQ-018 SHALL use states EMPTY, ONE (main valid), FULL (main and skid valid).
REQ-019 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, decoded from registered state only (no in->out combinational path).
REQ-020 Accept = in_valid & in_ready; consume = out_valid & out_ready.
REQ-021 EMPTY: accept -> main<=in, ONE; otherwise stay.
REQ-022 ONE: consume & accept -> main<=in, stay ONE; consume only -> EMPTY; accept only -> skid<=in, FULL; neither -> hold.
REQ-023 FULL: consume -> main<=skid, ONE; otherwise hold both registers unchanged.
REQ-024 Latency SHALL be exactly one cycle from accept to out_valid when empty; entries leave strictly in arrival order.
REQ-025 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-026 In EMPTY, out_ctrl SHALL equal CTRL_NOP and out_data SHALL be zero.
REQ-027 flush SHALL take priority over every other event: next state EMPTY, main and skid cleared (data zero, ctrl CTRL_NOP); an entry accepted in the flush cycle is discarded.
REQ-028 A consume in the flush cycle SHALL still count as a completed handshake for downstream; no other state survives.
REQ-029 bubble_cnt SHALL increment by 1 when out_valid=0 and out_ready=1, saturate at all-ones, and be unaffected by flush.

Reset
REQ-030 Asserting reset SHALL immediately force state EMPTY, out_valid=0, in_ready=1, out_data=0, out_ctrl=CTRL_NOP, skid cleared, bubble_cnt=0.
REQ-031 Reset asserted mid-operation (ONE or FULL) SHALL drop all entries; first accept after release is treated as an EMPTY-state accept.

Structure
REQ-032 DATA_WIDTH, REG_ADDR_WIDTH and the CTRL_* disable encodings used to build CTRL_NOP SHALL come from the shared mips_pkg.vh; no new constants are defined locally besides state encodings.
REQ-033 The bubble counter SHALL be a separate sub-module sat_counter (parameter W, inc input, synchronous clear-free, async reset).
REQ-034 The ID/EX, EX/MEM and MEM/WB stages SHALL instantiate pipe_latch with packed field bundles instead of per-stage latch modules.

Verification
REQ-035 Reset then in_valid=1, in_data=0x11, out_ready=1 -> next cycle out_valid=1, out_data=0x11, in_ready=1.
REQ-036 Stream 0x1,0x2,0x3 with out_ready=0 from cycle 2 -> state FULL, in_ready=0, out_data=0x1; raise out_ready -> outputs 0x1,0x2, then 0x3 accepted; no loss or reordering.
REQ-037 FULL, flush=1 with in_valid=1 in_data=0x55 -> next cycle out_valid=0, out_ctrl=CTRL_NOP, out_data=0, in_ready=1; 0x55 never appears.
REQ-038 Reset asserted asynchronously mid-cycle in ONE -> out_valid falls before next clk edge, out_ctrl=CTRL_NOP.
REQ-039 CNT_W=4, out_valid=0, out_ready=1 for 20 cycles -> bubble_cnt=15 and holds; flush in between does not clear it.
REQ-040 Random in_valid/out_ready with occasional flush, 10k cycles -> scoreboard: every non-flushed accepted entry output once, in order.
